// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// cpu_run_ctrl : holds/releases the cpu, counts run cycles, detects halt,
//                drains the pipeline, then streams nonzero data-memory words.
// Revision 1.0
// ============================================================================
module cpu_run_ctrl #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 16,
    parameter int                RESET_CYCLES = 4,
    parameter int                DRAIN_CYCLES = 10,
    parameter logic [31:0]       MAX_CYCLES   = 32'd1000000,
    parameter logic [DATA_W-1:0] HALT_A       = 16'hE000,
    parameter logic [DATA_W-1:0] HALT_B       = 16'hE7FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              cpu_reset,
    input  logic [DATA_W-1:0] cpu_instr,
    output logic              mem_own,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count
);

    localparam int c_CNT_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1) + 1;
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(RESET_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(DRAIN_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_OUT     = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_cpu_reset;
    logic                r_mem_own;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_dump_valid;
    logic [ADDR_W-1:0]   r_dump_addr;
    logic [DATA_W-1:0]   r_dump_data;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic [31:0]         r_cycle_count;

    logic                w_is_halt;
    logic                w_last_addr;
    logic [31:0]         w_count_inc;
    logic                w_timeout_hit;

    assign w_is_halt     = (cpu_instr == HALT_A) || (cpu_instr == HALT_B);
    assign w_last_addr   = (r_mem_addr == c_LAST_ADDR);
    assign w_count_inc   = (r_cycle_count == 32'hFFFF_FFFF) ? r_cycle_count
                                                            : r_cycle_count + 32'd1;
    // Timeout fires on the edge whose incremented count reaches the limit.
    assign w_timeout_hit = (MAX_CYCLES != 32'd0) && (w_count_inc >= MAX_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cpu_reset   <= 1'b1;
            r_mem_own     <= 1'b0;
            r_mem_addr    <= '0;
            r_dump_valid  <= 1'b0;
            r_dump_addr   <= '0;
            r_dump_data   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_HOLD;
                        r_cnt         <= c_CNT_ONE;
                        r_cycle_count <= '0;
                        r_timeout     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_cpu_reset   <= 1'b1;
                        r_mem_own     <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (r_cnt >= c_HOLD_LAST) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_RUN: begin
                    r_cycle_count <= w_count_inc;
                    // Halt takes precedence when both land on the same edge.
                    if (w_is_halt || w_timeout_hit) begin
                        r_state   <= S_DRAIN;
                        r_timeout <= ~w_is_halt;
                        r_cnt     <= c_CNT_ONE;
                    end
                end

                S_DRAIN: begin
                    if (r_cnt >= c_DRAIN_LAST) begin
                        r_state     <= S_RD_ADDR;
                        r_cpu_reset <= 1'b1;
                        r_mem_own   <= 1'b1;
                        r_mem_addr  <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_RD_ADDR: begin
                    r_state <= S_RD_DATA;
                end

                S_RD_DATA: begin
                    if (mem_rdata != '0) begin
                        r_dump_valid <= 1'b1;
                        r_dump_addr  <= r_mem_addr;
                        r_dump_data  <= mem_rdata;
                        r_state      <= S_OUT;
                    end else if (w_last_addr) begin
                        r_state   <= S_DONE;
                        r_mem_own <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                        r_state    <= S_RD_ADDR;
                    end
                end

                S_OUT: begin
                    if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (w_last_addr) begin
                            r_state   <= S_DONE;
                            r_mem_own <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_mem_addr <= r_mem_addr + 1'b1;
                            r_state    <= S_RD_ADDR;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_reset   = r_cpu_reset;
    assign mem_own     = r_mem_own;
    assign mem_addr    = r_mem_addr;
    assign dump_valid  = r_dump_valid;
    assign dump_addr   = r_dump_addr;
    assign dump_data   = r_dump_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire
